// File: rtl/fpu_defs.sv
// fpu_defs: shared FPU constants for the issue controller slice.
// Operand/command/rounding widths, command encodings, the quiet-NaN
// pattern, the flag index layout {OF,UF,Zero,IX,IV,Inf} and the flags type.
package fpu_defs;

   localparam int C_OP          = 32;
   localparam int C_CMD         = 4;
   localparam int C_RM          = 3;
   localparam int C_TAG_DEFAULT = 4;
   localparam int C_FLAGS       = 6;

   localparam logic [C_OP-1:0] F_QNAN = 32'h7FC0_0000;

   localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'd0;
   localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'd1;
   localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'd2;

   // Flag bit positions, MSB first: {OF, UF, Zero, IX, IV, Inf}
   localparam int FLAG_OF   = 5;
   localparam int FLAG_UF   = 4;
   localparam int FLAG_ZERO = 3;
   localparam int FLAG_IX   = 2;
   localparam int FLAG_IV   = 1;
   localparam int FLAG_INF  = 0;

   typedef logic [C_FLAGS-1:0] fpu_flags_t;

   // True for the commands this controller forwards to the FPU core.
   function automatic logic is_legal_cmd(input logic [C_CMD-1:0] op);
      logic legal;
      case (op)
         C_FPU_ADD_CMD,
         C_FPU_SUB_CMD,
         C_FPU_MUL_CMD: legal = 1'b1;
         default:       legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Flags reported for a rejected command: invalid-operation only.
   function automatic fpu_flags_t flags_iv_only();
      fpu_flags_t flags;
      flags          = '0;
      flags[FLAG_IV] = 1'b1;
      return flags;
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: request/response handshake bundle of the FPU issue
// controller. master = requester side, slave = the controller.
interface fpu_issue_ctrl_if #(
   parameter int C_TAG = fpu_defs::C_TAG_DEFAULT
) ();
   import fpu_defs::*;

   logic                Req_Valid_SI;
   logic [C_OP-1:0]     Req_Operand_a_DI;
   logic [C_OP-1:0]     Req_Operand_b_DI;
   logic [C_CMD-1:0]    Req_OP_SI;
   logic [C_RM-1:0]     Req_RM_SI;
   logic [C_TAG-1:0]    Req_Tag_DI;
   logic                Req_Ready_SO;

   logic                Resp_Valid_SO;
   logic [C_OP-1:0]     Resp_Result_DO;
   logic [C_TAG-1:0]    Resp_Tag_DO;
   fpu_flags_t          Resp_Flags_DO;
   logic                Resp_Ready_SI;

   modport master (
      output Req_Valid_SI, Req_Operand_a_DI, Req_Operand_b_DI, Req_OP_SI,
             Req_RM_SI, Req_Tag_DI, Resp_Ready_SI,
      input  Req_Ready_SO, Resp_Valid_SO, Resp_Result_DO, Resp_Tag_DO,
             Resp_Flags_DO
   );

   modport slave (
      input  Req_Valid_SI, Req_Operand_a_DI, Req_Operand_b_DI, Req_OP_SI,
             Req_RM_SI, Req_Tag_DI, Resp_Ready_SI,
      output Req_Ready_SO, Resp_Valid_SO, Resp_Result_DO, Resp_Tag_DO,
             Resp_Flags_DO
   );

endinterface

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: result buffer for the FPU issue controller.
// Power-of-two depth, pointers wrap naturally at C_DEPTH. Push and pop in
// the same cycle are allowed at any occupancy; the caller guarantees no
// push while full and no pop while empty.
module fpu_issue_fifo #(
   parameter int C_WIDTH = 8,
   parameter int C_DEPTH = 4
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RBI,
   input  logic                      Push_SI,
   input  logic [C_WIDTH-1:0]        Data_DI,
   input  logic                      Pop_SI,
   output logic [C_WIDTH-1:0]        Data_DO,
   output logic                      Full_SO,
   output logic                      Empty_SO,
   output logic [$clog2(C_DEPTH):0]  Count_DO
);

   localparam int C_PTR_W = $clog2(C_DEPTH);
   localparam int C_CNT_W = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0] C_DEPTH_V = C_CNT_W'(C_DEPTH);

   logic [C_WIDTH-1:0] mem_q [C_DEPTH];
   logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_CNT_W-1:0] count_q, count_d;

   // Pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (Push_SI) begin
         wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (Pop_SI) begin
         rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({Push_SI, Pop_SI})
         2'b10:   count_d = count_q + C_CNT_W'(1);
         2'b01:   count_d = count_q - C_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only visible through the non-empty head
   always_ff @(posedge Clk_CI) begin
      if (Push_SI) begin
         mem_q[wr_ptr_q] <= Data_DI;
      end
   end

   assign Data_DO  = mem_q[rd_ptr_q];
   assign Full_SO  = (count_q == C_DEPTH_V);
   assign Empty_SO = (count_q == '0);
   assign Count_DO = count_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: credit-based issue controller in front of an FPU core.
// Legal requests (ADD/SUB/MUL) are forwarded combinationally to the core;
// one cycle later its result is captured with the request tag into a FIFO
// result buffer and returned in issue order. Illegal commands are accepted
// and answered with a quiet NaN. Err_SO is a sticky core-protocol error.
// Optional build macro FPU_ISSUE_FLAGS_EN: keep 6 exception flags per
// entry and return them on Resp_Flags_DO (otherwise flags are tied to 0).
module fpu_issue_ctrl
   import fpu_defs::*;
#(
   parameter int C_TAG   = fpu_defs::C_TAG_DEFAULT,
   parameter int C_DEPTH = 4
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,

   fpu_issue_ctrl_if.slave       bus,

   output logic                  Fpu_Enable_SO,
   output logic [C_OP-1:0]       Fpu_Operand_a_DO,
   output logic [C_OP-1:0]       Fpu_Operand_b_DO,
   output logic [C_CMD-1:0]      Fpu_OP_SO,
   output logic [C_RM-1:0]       Fpu_RM_SO,

   input  logic [C_OP-1:0]       Fpu_Result_DI,
   input  logic                  Fpu_Valid_SI,
   input  fpu_flags_t            Fpu_Flags_DI,

   output logic                  Err_SO
);

   localparam int C_PTR_W = $clog2(C_DEPTH);
   localparam int C_CNT_W = C_PTR_W + 1;
`ifdef FPU_ISSUE_FLAGS_EN
   localparam int C_ENTRY_W = C_OP + C_TAG + C_FLAGS;
`else
   localparam int C_ENTRY_W = C_OP + C_TAG;
`endif
   localparam logic [C_CNT_W:0] C_DEPTH_V = (C_CNT_W + 1)'(C_DEPTH);

   logic                 issue_s;
   logic                 legal_s;
   logic                 fpu_fire_s;
   logic                 legal_inflight_s;

   logic                 inflight_q, inflight_d;
   logic [C_TAG-1:0]     inflight_tag_q, inflight_tag_d;
   logic                 illegal_q, illegal_d;
   logic                 err_q, err_d;

   logic [C_CNT_W-1:0]   fifo_count_s;
   logic [C_CNT_W:0]     occupancy_s;
   logic                 fifo_empty_s;
   logic                 fifo_full_unused_s;
   logic                 push_s;
   logic                 pop_s;
   logic [C_OP-1:0]      push_result_s;
   logic [C_ENTRY_W-1:0] push_data_s;
   logic [C_ENTRY_W-1:0] head_data_s;

   // Credits: buffered entries plus the one in flight must leave a free slot.
   // Built from registers only, so Resp_Ready_SI never reaches Req_Ready_SO.
   assign occupancy_s      = {1'b0, fifo_count_s} + {{C_CNT_W{1'b0}}, inflight_q};
   assign bus.Req_Ready_SO = (occupancy_s < C_DEPTH_V);

   assign issue_s    = bus.Req_Valid_SI & bus.Req_Ready_SO;
   assign legal_s    = is_legal_cmd(bus.Req_OP_SI);
   assign fpu_fire_s = issue_s & legal_s;

   // Forward legal requests to the core; idle core inputs are held at zero
   always_comb begin
      if (fpu_fire_s) begin
         Fpu_Enable_SO    = 1'b1;
         Fpu_Operand_a_DO = bus.Req_Operand_a_DI;
         Fpu_Operand_b_DO = bus.Req_Operand_b_DI;
         Fpu_OP_SO        = bus.Req_OP_SI;
         Fpu_RM_SO        = bus.Req_RM_SI;
      end else begin
         Fpu_Enable_SO    = 1'b0;
         Fpu_Operand_a_DO = '0;
         Fpu_Operand_b_DO = '0;
         Fpu_OP_SO        = '0;
         Fpu_RM_SO        = '0;
      end
   end

   // In-flight stage next-state: valid only for the cycle after an issue
   always_comb begin
      inflight_d = issue_s;
      if (issue_s) begin
         inflight_tag_d = bus.Req_Tag_DI;
         illegal_d      = ~legal_s;
      end else begin
         inflight_tag_d = inflight_tag_q;
         illegal_d      = illegal_q;
      end
   end

   assign legal_inflight_s = inflight_q & ~illegal_q;

   // Sticky error: core answers with nothing pending, or stays silent when due
   always_comb begin
      if (err_q) begin
         err_d = 1'b1;
      end else begin
         err_d = (Fpu_Valid_SI & ~legal_inflight_s) | (~Fpu_Valid_SI & legal_inflight_s);
      end
   end

   // In-flight stage and error flag registers
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         inflight_q     <= 1'b0;
         inflight_tag_q <= '0;
         illegal_q      <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         inflight_q     <= inflight_d;
         inflight_tag_q <= inflight_tag_d;
         illegal_q      <= illegal_d;
         err_q          <= err_d;
      end
   end

   assign Err_SO = err_q;

   // Result captured for the in-flight op; a missing core answer still
   // writes an entry (zero result) so the response stream stays aligned.
   always_comb begin
      if (illegal_q) begin
         push_result_s = F_QNAN;
      end else if (Fpu_Valid_SI) begin
         push_result_s = Fpu_Result_DI;
      end else begin
         push_result_s = '0;
      end
   end

   assign push_s = inflight_q;

`ifdef FPU_ISSUE_FLAGS_EN
   fpu_flags_t push_flags_s;

   // Flags captured alongside the result
   always_comb begin
      if (illegal_q) begin
         push_flags_s = flags_iv_only();
      end else if (Fpu_Valid_SI) begin
         push_flags_s = Fpu_Flags_DI;
      end else begin
         push_flags_s = '0;
      end
   end

   assign push_data_s = {push_result_s, inflight_tag_q, push_flags_s};
`else
   logic unused_flags_s;

   assign unused_flags_s = ^Fpu_Flags_DI;
   assign push_data_s    = {push_result_s, inflight_tag_q};
`endif

   fpu_issue_fifo #(
      .C_WIDTH (C_ENTRY_W),
      .C_DEPTH (C_DEPTH)
   ) i_fifo (
      .Clk_CI   (Clk_CI),
      .Rst_RBI  (Rst_RBI),
      .Push_SI  (push_s),
      .Data_DI  (push_data_s),
      .Pop_SI   (pop_s),
      .Data_DO  (head_data_s),
      .Full_SO  (fifo_full_unused_s),
      .Empty_SO (fifo_empty_s),
      .Count_DO (fifo_count_s)
   );

   assign bus.Resp_Valid_SO = ~fifo_empty_s;
   assign pop_s             = bus.Resp_Valid_SO & bus.Resp_Ready_SI;

   // Present the buffer head; data reads as zero whenever nothing is valid
   always_comb begin
      if (!fifo_empty_s) begin
         bus.Resp_Result_DO = head_data_s[C_ENTRY_W-1 -: C_OP];
         bus.Resp_Tag_DO    = head_data_s[C_ENTRY_W-C_OP-1 -: C_TAG];
`ifdef FPU_ISSUE_FLAGS_EN
         bus.Resp_Flags_DO  = head_data_s[C_FLAGS-1:0];
`else
         bus.Resp_Flags_DO  = '0;
`endif
      end else begin
         bus.Resp_Result_DO = '0;
         bus.Resp_Tag_DO    = '0;
         bus.Resp_Flags_DO  = '0;
      end
   end

endmodule
